ntt_coeff_loader: RTL and testbench

//   Upstream feeder for simple_ntt_core. Accepts a valid/ready stream of coefficients and packs

---
 rtl/ntt_coeff_loader.sv | 135 +++++++++++++
 tb/tb_ntt_coeff_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coeff_loader.sv
// Coefficient frame loader feeding simple_ntt_core: packs a valid/ready stream into 4 slots, holds, then sweeps index 0..3.
// Optional `define MOD_REDUCE_EN enables a single conditional mod-q subtract on each stored coefficient.
module ntt_coeff_loader #(
    parameter int unsigned              data_width  = 32,
    parameter int unsigned              buffer_size = 4,
    parameter logic [data_width-1:0]    modulus     = data_width'(7681)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  start,
    output logic [data_width-1:0] out_buffer0,
    output logic [data_width-1:0] out_buffer1,
    output logic [data_width-1:0] out_buffer2,
    output logic [data_width-1:0] out_buffer3,
    output logic [1:0]            index,
    output logic                  buf_valid,
    output logic                  sweeping,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            wr_ptr_q;
    logic [1:0]            index_q;
    logic                  frame_done_q;
    logic [data_width-1:0] slot_q [buffer_size];
    logic [data_width-1:0] stored;
    logic                  accept;
    logic                  frame_close;
    logic                  sweep_end;

`ifdef MOD_REDUCE_EN
    // One subtract only: values >= 2*modulus leave still unreduced.
    assign stored = (in_data >= modulus) ? in_data - modulus : in_data;
`else
    assign stored = in_data;
    wire unused_modulus = ^modulus;
`endif

    // in_ready is masked by reset so the producer never sees a handshake while the block is held in reset.
    assign in_ready = (state_q == FILL) && !reset;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        accept      = 1'b0;
        frame_close = 1'b0;
        sweep_end   = 1'b0;
        case (state_q)
            FILL: begin
                accept      = in_valid && in_ready;
                frame_close = accept && ((wr_ptr_q == 2'd3) || in_last);
                if (frame_close) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                sweep_end = (index_q == 2'd3);
                if (sweep_end) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            index_q      <= '0;
            frame_done_q <= 1'b0;
            // NOTE: the slot array is only 4 words and drives visible outputs, so it is cleared on reset.
            for (int k = 0; k < int'(buffer_size); k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            frame_done_q <= sweep_end;

            if (accept) begin
                slot_q[wr_ptr_q] <= stored;
                wr_ptr_q         <= frame_close ? 2'd0 : wr_ptr_q + 2'd1;
                // A short frame zero-pads the slots after the last coefficient.
                if (in_last) begin
                    for (int k = 0; k < int'(buffer_size); k++) begin
                        if (k > int'(wr_ptr_q)) begin
                            slot_q[k] <= '0;
                        end
                    end
                end
            end

            if (state_q == SWEEP) begin
                index_q <= sweep_end ? 2'd0 : index_q + 2'd1;
            end else begin
                index_q <= 2'd0;
            end
        end
    end

    assign out_buffer0 = slot_q[0];
    assign out_buffer1 = slot_q[1];
    assign out_buffer2 = slot_q[2];
    assign out_buffer3 = slot_q[3];
    assign index       = index_q;
    assign buf_valid   = (state_q != FILL);
    assign sweeping    = (state_q == SWEEP);
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Self-checking bench for ntt_coeff_loader: directed frames plus randomized frames against a slot-array model.
module tb_ntt_coeff_loader;

    localparam int DW = 32;
    localparam logic [DW-1:0] Q = 32'd7681;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          start;
    logic [DW-1:0] out_buffer0, out_buffer1, out_buffer2, out_buffer3;
    logic [1:0]    index;
    logic          buf_valid;
    logic          sweeping;
    logic          frame_done;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] mdl [4];

    ntt_coeff_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .start       (start),
        .out_buffer0 (out_buffer0),
        .out_buffer1 (out_buffer1),
        .out_buffer2 (out_buffer2),
        .out_buffer3 (out_buffer3),
        .index       (index),
        .buf_valid   (buf_valid),
        .sweeping    (sweeping),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic rdy, input logic bv, input logic sw,
                             input logic [1:0] idx, input logic fd);
        check({tag, ".in_ready"},   DW'(in_ready),   DW'(rdy));
        check({tag, ".buf_valid"},  DW'(buf_valid),  DW'(bv));
        check({tag, ".sweeping"},   DW'(sweeping),   DW'(sw));
        check({tag, ".index"},      DW'(index),      DW'(idx));
        check({tag, ".frame_done"}, DW'(frame_done), DW'(fd));
    endtask

    task automatic check_slots(input string tag);
        check({tag, ".slot0"}, out_buffer0, mdl[0]);
        check({tag, ".slot1"}, out_buffer1, mdl[1]);
        check({tag, ".slot2"}, out_buffer2, mdl[2]);
        check({tag, ".slot3"}, out_buffer3, mdl[3]);
    endtask

    function automatic logic [DW-1:0] reduce(input logic [DW-1:0] v);
`ifdef MOD_REDUCE_EN
        return (v >= Q) ? v - Q : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one frame starting from an empty write pointer; model: value i lands in slot i, in_last zeroes the rest.
    task automatic load_frame(input logic [DW-1:0] vals[$], input bit use_last, input bit gaps);
        for (int i = 0; i < vals.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                start    = 1'($urandom_range(0, 1));
                tick();
                check_ctl("fill_gap", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
                check_slots("fill_gap");
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            in_last  = use_last && (i == vals.size() - 1);
            start    = 1'($urandom_range(0, 1));
            #1;
            check("pre_accept.in_ready", DW'(in_ready), DW'(1'b1));
            tick();
            mdl[i] = reduce(vals[i]);
            if (in_last) begin
                for (int j = i + 1; j < 4; j++) mdl[j] = '0;
            end
            if (i != vals.size() - 1) begin
                check("mid_fill.buf_valid", DW'(buf_valid), DW'(1'b0));
                check_slots("mid_fill");
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        check_ctl("frame_held", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_slots("frame_held");
    endtask

    // Holds with in_valid asserted, then sweeps; optionally aborts with reset when index reaches 2.
    task automatic hold_and_sweep(input int hold_cycles, input bit reset_at2);
        bit aborted = 1'b0;
        in_valid = 1'b1;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
        for (int c = 0; c < hold_cycles; c++) begin
            tick();
            check_ctl("hold", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
            check_slots("hold");
        end
        start = 1'b1;
        tick();
        for (int k = 0; k < 4 && !aborted; k++) begin
            start = 1'($urandom_range(0, 1));
            check_ctl("sweep", 1'b0, 1'b1, 1'b1, 2'(k), 1'b0);
            check_slots("sweep");
            if (reset_at2 && k == 2) begin
                aborted = 1'b1;
                reset   = 1'b1;
                #1;
                check("reset_asserted.in_ready", DW'(in_ready), DW'(1'b0));
                tick();
                for (int j = 0; j < 4; j++) mdl[j] = '0;
                check_ctl("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
                check_slots("mid_reset");
                in_valid = 1'b0;
                start    = 1'b0;
                in_last  = 1'b0;
                reset    = 1'b0;
                #1;
                check_ctl("after_reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
                tick();
                check_ctl("after_reset_edge", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            end else if (k < 3) begin
                tick();
            end
        end
        if (!aborted) begin
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            start    = 1'b0;
            check_ctl("sweep_end", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
            check_slots("sweep_end");
            tick();
            check_ctl("post_done", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            check_slots("post_done");
        end
    endtask

    initial begin
        logic [DW-1:0] vals[$];
        int            len;
        bit            use_last;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        for (int j = 0; j < 4; j++) mdl[j] = '0;

        tick();
        tick();
        check_ctl("in_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check_slots("in_reset");
        reset = 1'b0;
        #1;
        check("reset_release.in_ready", DW'(in_ready), DW'(1'b1));

        vals = '{32'd1, 32'd2, 32'd3, 32'd4};
        load_frame(vals, 1'b0, 1'b0);
        hold_and_sweep(2, 1'b0);

        vals = '{32'd9, 32'd5};
        load_frame(vals, 1'b1, 1'b0);
        hold_and_sweep(1, 1'b0);

        // start must be ignored while filling
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check_ctl("start_in_fill", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        vals = '{32'd10, 32'd20, 32'd30, 32'd40};
        load_frame(vals, 1'b1, 1'b0);
        hold_and_sweep(0, 1'b0);

        vals = '{32'd11, 32'd12, 32'd13};
        load_frame(vals, 1'b1, 1'b1);
        hold_and_sweep(1, 1'b1);

`ifdef MOD_REDUCE_EN
        vals = '{32'd7680, 32'd7681, 32'd7690, 32'd15362};
        load_frame(vals, 1'b0, 1'b0);
        check("modq.slot0", out_buffer0, 32'd7680);
        check("modq.slot1", out_buffer1, 32'd0);
        check("modq.slot2", out_buffer2, 32'd9);
        check("modq.slot3", out_buffer3, 32'd7681);
        hold_and_sweep(0, 1'b0);
`endif

        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 4);
            use_last = (len < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            vals.delete();
            for (int i = 0; i < len; i++) begin
                vals.push_back(($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 20000)) : DW'($urandom));
            end
            load_frame(vals, use_last, 1'b1);
            hold_and_sweep($urandom_range(0, 3), (f % 9) == 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
